accel_core: RTL and testbench

//  Top datapath of the 2D accelerator: 2048x32b activation/weight SRAM (xmem), L0 input FIFO,
//  8x8 4-bit MAC array, output FIFO, 2048x128b psum SRAM (pmem), accumulate+ReLU SFP stage.

---
 rtl/core_pkg.sv | 38 +++
 rtl/mac_array.sv | 158 +++++++++++++++
 rtl/accel_core.sv | 159 +++++++++++++++
 tb/tb_accel_core.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants for the 2D accelerator core: instruction bit positions, default
// geometry, FIFO sizing and the dataflow mode encoding.
package core_pkg;

  localparam int ROW_DEF     = 8;
  localparam int COL_DEF     = 8;
  localparam int BW_DEF      = 4;
  localparam int PSUM_BW_DEF = 16;
  localparam int NUM_DEF     = 2048;
  localparam int ADDR_W      = 11;

  localparam int FIFO_DEPTH  = 64;
  localparam int FIFO_AW     = 6;
  localparam int FIFO_CW     = 7;

  localparam int INST_W        = 35;
  localparam int INST_MODE     = 34;
  localparam int INST_ACC      = 33;
  localparam int INST_CEN_PMEM = 32;
  localparam int INST_WEN_PMEM = 31;
  localparam int INST_A_PMEM   = 20;
  localparam int INST_CEN_XMEM = 19;
  localparam int INST_WEN_XMEM = 18;
  localparam int INST_A_XMEM   = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXECUTE  = 1;
  localparam int INST_LOAD     = 0;

  typedef enum logic {
    MODE_WS = 1'b0,
    MODE_OS = 1'b1
  } mode_e;

endpackage

// File: rtl/mac_array.sv
// 8x8 MAC grid: weights shift in west->east on load; WS mode is a skewed systolic pass
// (15 cycles to a deskewed row), OS mode a one-cycle per-column dot product. No backpressure.
module mac_array
  import core_pkg::*;
#(
  parameter int ROW     = ROW_DEF,
  parameter int COL     = COL_DEF,
  parameter int BW      = BW_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  mode_e                  mode,
  input  logic                   load_vld,
  input  logic                   exec_vld,
  input  logic [ROW*BW-1:0]      in_dat,
  output logic                   out_vld,
  output logic [COL*PSUM_BW-1:0] out_dat
);

  // Activations are unsigned, weights signed; the product wraps to the psum width.
  function automatic logic signed [PSUM_BW-1:0] mul(input logic [BW-1:0] a, input logic [BW-1:0] w);
    logic signed [PSUM_BW-1:0] ax, wx;
    ax = $signed({{(PSUM_BW-BW){1'b0}}, a});
    wx = $signed({{(PSUM_BW-BW){w[BW-1]}}, w});
    return ax * wx;
  endfunction

  logic                      ws_in, os_in;
  logic [BW-1:0]             w_q    [ROW][COL];
  logic [BW-1:0]             sk_a_q [ROW][ROW-1];
  logic                      sk_v_q [ROW][ROW-1];
  logic [BW-1:0]             s_a    [ROW][ROW];
  logic                      s_v    [ROW][ROW];
  logic [BW-1:0]             a_q    [ROW][COL];
  logic                      v_q    [ROW][COL];
  logic [BW-1:0]             a_w    [ROW][COL];
  logic                      v_w    [ROW][COL];
  logic signed [PSUM_BW-1:0] p_q    [ROW][COL];
  logic signed [PSUM_BW-1:0] p_in   [ROW][COL];
  logic signed [PSUM_BW-1:0] p_d    [ROW][COL];
  logic signed [PSUM_BW-1:0] ds_p_q [COL][COL-1];
  logic                      ds_v_q [COL][COL-1];
  logic signed [PSUM_BW-1:0] d_p    [COL][COL];
  logic                      d_v    [COL][COL];
  logic signed [PSUM_BW-1:0] os_sum [COL];
  logic [COL*PSUM_BW-1:0]    os_dat_q, ws_dat;
  logic                      os_vld_q, ws_vld;

  assign ws_in = exec_vld && (mode == MODE_WS);
  assign os_in = exec_vld && (mode == MODE_OS);

  // Row r enters the grid r cycles late; stage 0 of each chain is the live input.
  always_comb begin
    for (int r = 0; r < ROW; r++) begin
      s_a[r][0] = in_dat[r*BW +: BW];
      s_v[r][0] = ws_in;
      for (int k = 1; k < ROW; k++) begin
        s_a[r][k] = sk_a_q[r][k-1];
        s_v[r][k] = sk_v_q[r][k-1];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ROW; r++) begin
      a_w[r][0] = s_a[r][r];
      v_w[r][0] = s_v[r][r];
      for (int c = 1; c < COL; c++) begin
        a_w[r][c] = a_q[r][c-1];
        v_w[r][c] = v_q[r][c-1];
      end
    end
    for (int c = 0; c < COL; c++) begin
      p_in[0][c] = '0;
      for (int r = 1; r < ROW; r++) p_in[r][c] = p_q[r-1][c];
    end
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++)
        p_d[r][c] = p_in[r][c] + mul(a_w[r][c], w_q[r][c]);
  end

  // Column c leaves the bottom row c cycles after column 0; delay it 7-c more to realign.
  always_comb begin
    ws_vld = 1'b1;
    ws_dat = '0;
    for (int c = 0; c < COL; c++) begin
      d_p[c][0] = p_q[ROW-1][c];
      d_v[c][0] = v_q[ROW-1][c];
      for (int k = 1; k < COL; k++) begin
        d_p[c][k] = ds_p_q[c][k-1];
        d_v[c][k] = ds_v_q[c][k-1];
      end
      ws_dat[c*PSUM_BW +: PSUM_BW] = d_p[c][COL-1-c];
      ws_vld = ws_vld & d_v[c][COL-1-c];
    end
  end

  always_comb begin
    for (int c = 0; c < COL; c++) begin
      os_sum[c] = '0;
      for (int r = 0; r < ROW; r++) os_sum[c] = os_sum[c] + mul(in_dat[r*BW +: BW], w_q[r][c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROW; r++) begin
        for (int k = 0; k < ROW-1; k++) begin
          sk_a_q[r][k] <= '0;
          sk_v_q[r][k] <= 1'b0;
        end
        for (int c = 0; c < COL; c++) begin
          w_q[r][c] <= '0;
          a_q[r][c] <= '0;
          v_q[r][c] <= 1'b0;
          p_q[r][c] <= '0;
        end
      end
      for (int c = 0; c < COL; c++)
        for (int k = 0; k < COL-1; k++) begin
          ds_p_q[c][k] <= '0;
          ds_v_q[c][k] <= 1'b0;
        end
      os_dat_q <= '0;
      os_vld_q <= 1'b0;
    end else begin
      for (int r = 0; r < ROW; r++) begin
        for (int k = 0; k < ROW-1; k++) begin
          sk_a_q[r][k] <= s_a[r][k];
          sk_v_q[r][k] <= s_v[r][k];
        end
        for (int c = 0; c < COL; c++) begin
          a_q[r][c] <= a_w[r][c];
          v_q[r][c] <= v_w[r][c];
          p_q[r][c] <= p_d[r][c];
        end
        if (load_vld) begin
          w_q[r][0] <= in_dat[r*BW +: BW];
          for (int c = 1; c < COL; c++) w_q[r][c] <= w_q[r][c-1];
        end
      end
      for (int c = 0; c < COL; c++)
        for (int k = 0; k < COL-1; k++) begin
          ds_p_q[c][k] <= d_p[c][k];
          ds_v_q[c][k] <= d_v[c][k];
        end
      if (os_in)
        for (int c = 0; c < COL; c++) os_dat_q[c*PSUM_BW +: PSUM_BW] <= os_sum[c];
      os_vld_q <= os_in;
    end
  end

  // A mid-execute mode flip can collide both paths in one cycle; WS wins, OS result dropped.
  assign out_vld = ws_vld | os_vld_q;
  assign out_dat = ws_vld ? ws_dat : os_dat_q;

endmodule

// File: rtl/accel_core.sv
// Accelerator datapath: xmem -> L0 -> MAC array -> OFIFO -> pmem -> accumulate/ReLU.
// SRAM reads return next cycle; full FIFOs drop pushes, empty FIFOs ignore pops and yield 0.
module accel_core
  import core_pkg::*;
#(
  parameter int row     = ROW_DEF,
  parameter int col     = COL_DEF,
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int num     = NUM_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INST_W-1:0]      inst,
  input  logic [bw*row-1:0]      D_xmem,
  output logic                   valid,
  output logic [col*psum_bw-1:0] coreOut
);

  localparam logic [FIFO_CW-1:0] FIFO_FULL = FIFO_CW'(FIFO_DEPTH);

  mode_e               mode;
  logic [ADDR_W-1:0]   ax, ap;
  logic                x_cen, x_wen, p_cen, p_wen;
  logic                unused_inst;

  assign mode  = mode_e'(inst[INST_MODE]);
  assign ax    = inst[INST_A_XMEM +: ADDR_W];
  assign ap    = inst[INST_A_PMEM +: ADDR_W];
  assign x_cen = inst[INST_CEN_XMEM];
  assign x_wen = inst[INST_WEN_XMEM];
  assign p_cen = inst[INST_CEN_PMEM];
  assign p_wen = inst[INST_WEN_PMEM];
  assign unused_inst = ^{inst[INST_IFIFO_WR], inst[INST_IFIFO_RD]};

  // SRAM arrays and their read registers survive reset.
  logic [bw*row-1:0] xmem [num];
  logic [bw*row-1:0] xq_q;

  always_ff @(posedge clk) begin
    if (!x_cen && !x_wen) xmem[ax] <= D_xmem;
    if (!x_cen && x_wen)  xq_q <= xmem[ax];
  end

  // The 8 row FIFOs always move in lockstep, so they share one set of pointers.
  logic [bw*row-1:0]  l0_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] l0_wp_q, l0_rp_q;
  logic [FIFO_CW-1:0] l0_cnt_q;
  logic               l0_wr_d1_q, x_rd_d1_q, l0_push, l0_pop;
  logic [bw*row-1:0]  l0_dat;

  assign l0_push = l0_wr_d1_q && x_rd_d1_q && (l0_cnt_q != FIFO_FULL);
  assign l0_pop  = inst[INST_L0_RD] && (l0_cnt_q != '0);
  assign l0_dat  = l0_pop ? l0_mem[l0_rp_q] : '0;

  always_ff @(posedge clk) begin
    if (l0_push) l0_mem[l0_wp_q] <= xq_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l0_wr_d1_q <= 1'b0;
      x_rd_d1_q  <= 1'b0;
      l0_wp_q    <= '0;
      l0_rp_q    <= '0;
      l0_cnt_q   <= '0;
    end else begin
      l0_wr_d1_q <= inst[INST_L0_WR];
      x_rd_d1_q  <= !x_cen && x_wen;
      if (l0_push) l0_wp_q <= l0_wp_q + FIFO_AW'(1);
      if (l0_pop)  l0_rp_q <= l0_rp_q + FIFO_AW'(1);
      l0_cnt_q <= l0_cnt_q + FIFO_CW'(l0_push) - FIFO_CW'(l0_pop);
    end
  end

  logic                   arr_vld;
  logic [col*psum_bw-1:0] arr_dat;

  mac_array #(
    .ROW     (row),
    .COL     (col),
    .BW      (bw),
    .PSUM_BW (psum_bw)
  ) u_mac_array (
    .clk      (clk),
    .rst_n    (reset),
    .mode     (mode),
    .load_vld (l0_pop && inst[INST_LOAD]),
    .exec_vld (l0_pop && inst[INST_EXECUTE]),
    .in_dat   (l0_dat),
    .out_vld  (arr_vld),
    .out_dat  (arr_dat)
  );

  logic [col*psum_bw-1:0] of_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]     of_wp_q, of_rp_q;
  logic [FIFO_CW-1:0]     of_cnt_q;
  logic                   of_push, of_pop;
  logic [col*psum_bw-1:0] pmem_d;

  assign of_push = arr_vld && (of_cnt_q != FIFO_FULL);
  assign of_pop  = inst[INST_OFIFO_RD] && (of_cnt_q != '0);
  assign pmem_d  = of_pop ? of_mem[of_rp_q] : '0;
  assign valid   = (of_cnt_q != '0);

  always_ff @(posedge clk) begin
    if (of_push) of_mem[of_wp_q] <= arr_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      of_wp_q  <= '0;
      of_rp_q  <= '0;
      of_cnt_q <= '0;
    end else begin
      if (of_push) of_wp_q <= of_wp_q + FIFO_AW'(1);
      if (of_pop)  of_rp_q <= of_rp_q + FIFO_AW'(1);
      of_cnt_q <= of_cnt_q + FIFO_CW'(of_push) - FIFO_CW'(of_pop);
    end
  end

  logic [col*psum_bw-1:0] pmem [num];
  logic [col*psum_bw-1:0] pq_q;

  always_ff @(posedge clk) begin
    if (!p_cen && !p_wen) pmem[ap] <= pmem_d;
    if (!p_cen && p_wen)  pq_q <= pmem[ap];
  end

  // acc is delayed one cycle so it lines up with the pmem read data it refers to.
  logic                      acc_d1_q;
  logic signed [psum_bw-1:0] acc_q [col];
  logic signed [psum_bw-1:0] acc_d [col];
  logic [col*psum_bw-1:0]    coreout_q;

  always_comb begin
    for (int c = 0; c < col; c++) begin
      acc_d[c] = acc_q[c];
      if (acc_d1_q) acc_d[c] = acc_q[c] + $signed(pq_q[c*psum_bw +: psum_bw]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_d1_q  <= 1'b0;
      coreout_q <= '0;
      for (int c = 0; c < col; c++) acc_q[c] <= '0;
    end else begin
      acc_d1_q <= inst[INST_ACC];
      for (int c = 0; c < col; c++) begin
        acc_q[c] <= acc_d[c];
        coreout_q[c*psum_bw +: psum_bw] <= acc_q[c][psum_bw-1] ? '0 : acc_q[c];
      end
    end
  end

  assign coreOut = coreout_q;

endmodule

// File: tb/tb_accel_core.sv
// Directed bench for accel_core: xmem access, WS/OS MAC passes into pmem, SFP ReLU, resets.
`timescale 1ns/1ps
module tb_accel_core;
  import core_pkg::*;

  logic         clk;
  logic         reset;
  logic [34:0]  inst;
  logic [31:0]  D_xmem;
  logic         valid;
  logic [127:0] coreOut;
  int           total;
  int           bad;

  accel_core dut (
    .clk     (clk),
    .reset   (reset),
    .inst    (inst),
    .D_xmem  (D_xmem),
    .valid   (valid),
    .coreOut (coreOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] ALL8  = {8{16'h0008}};
  localparam logic [127:0] NEG15 = {8{16'hFFF1}};
  localparam logic [127:0] ONES  = {8{16'h0001}};
  localparam logic [127:0] MIX   = {16'h0024, 16'hFFDC, 16'h0048, 16'hFFB8,
                                    16'h006C, 16'h00FC, 16'hFEE0, 16'h0000};
  localparam logic [127:0] SFP2  = {16'h0025, 16'h0000, 16'h0049, 16'h0000,
                                    16'h006D, 16'h00FD, 16'h0000, 16'h0001};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] nop();
    logic [34:0] i;
    i = '0;
    i[INST_CEN_PMEM] = 1'b1;
    i[INST_WEN_PMEM] = 1'b1;
    i[INST_CEN_XMEM] = 1'b1;
    i[INST_WEN_XMEM] = 1'b1;
    return i;
  endfunction

  task automatic tick(input logic [34:0] i);
    inst = i;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(nop());
  endtask

  task automatic xwr(input logic [10:0] a, input logic [31:0] d);
    logic [34:0] i;
    i = nop();
    i[INST_CEN_XMEM] = 1'b0;
    i[INST_WEN_XMEM] = 1'b0;
    i[INST_A_XMEM +: 11] = a;
    D_xmem = d;
    tick(i);
  endtask

  task automatic xrd(input logic [10:0] a, input logic l0w);
    logic [34:0] i;
    i = nop();
    i[INST_CEN_XMEM] = 1'b0;
    i[INST_A_XMEM +: 11] = a;
    i[INST_L0_WR] = l0w;
    tick(i);
  endtask

  task automatic l0_fill(input logic [10:0] a, input int n);
    for (int k = 0; k < n; k++) xrd(a + 11'(k), 1'b1);
    idle(1);
  endtask

  task automatic l0_pop(input int n, input logic ld, input logic ex, input logic md);
    logic [34:0] i;
    for (int k = 0; k < n; k++) begin
      i = nop();
      i[INST_L0_RD] = 1'b1;
      i[INST_LOAD] = ld;
      i[INST_EXECUTE] = ex;
      i[INST_MODE] = md;
      tick(i);
    end
  endtask

  task automatic drain(input logic [10:0] a, input int n);
    logic [34:0] i;
    for (int k = 0; k < n; k++) begin
      i = nop();
      i[INST_OFIFO_RD] = 1'b1;
      i[INST_CEN_PMEM] = 1'b0;
      i[INST_WEN_PMEM] = 1'b0;
      i[INST_A_PMEM +: 11] = a + 11'(k);
      tick(i);
    end
  endtask

  task automatic accp(input logic [10:0] a);
    logic [34:0] i;
    i = nop();
    i[INST_ACC] = 1'b1;
    i[INST_CEN_PMEM] = 1'b0;
    i[INST_A_PMEM +: 11] = a;
    tick(i);
    idle(3);
  endtask

  logic [31:0] pat [4];
  logic [31:0] wk  [8];
  logic [34:0] ex_i;

  initial begin
    total = 0;
    bad = 0;
    pat = '{32'hA5A5_5A5A, 32'h0123_4567, 32'hFFFF_0000, 32'hDEAD_BEEF};
    wk  = '{32'h1111_1111, 32'hFFFF_FFFF, 32'h2222_2222, 32'hEEEE_EEEE,
            32'h3333_3333, 32'h7777_7777, 32'h8888_8888, 32'h0000_0000};
    reset = 1'b0;
    inst = nop();
    D_xmem = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {127'b0, valid}, 128'd0);
    chk("rst_coreout", coreOut, 128'd0);
    chk("rst_l0_cnt", {121'b0, dut.l0_cnt_q}, 128'd0);
    chk("rst_of_cnt", {121'b0, dut.of_cnt_q}, 128'd0);
    reset = 1'b1;
    idle(1);

    // xmem write then read-back through the Q register
    for (int k = 0; k < 36; k++) xwr(11'(k), 32'h1111_1111);
    for (int k = 0; k < 8; k++) xwr(11'(1024 + k), 32'h1111_1111);
    for (int k = 0; k < 4; k++) xwr(11'(100 + k), pat[k]);
    for (int k = 0; k < 4; k++) begin
      xrd(11'(100 + k), 1'b0);
      chk($sformatf("xq_rd%0d", 100 + k), {96'b0, dut.xq_q}, {96'b0, pat[k]});
    end
    idle(2);
    chk("xq_hold", {96'b0, dut.xq_q}, {96'b0, pat[3]});
    xrd(11'd0, 1'b0);
    chk("xq_act0", {96'b0, dut.xq_q}, {96'b0, 32'h1111_1111});
    xrd(11'd1031, 1'b0);
    chk("xq_w7", {96'b0, dut.xq_q}, {96'b0, 32'h1111_1111});
    idle(1);
    chk("l0_no_push_without_wr", {121'b0, dut.l0_cnt_q}, 128'd0);

    // all-ones weights and activations, 36 nij in WS
    l0_fill(11'd1024, 8);
    l0_pop(8, 1'b1, 1'b0, 1'b0);
    chk("l0_empty_after_load", {121'b0, dut.l0_cnt_q}, 128'd0);
    l0_fill(11'd0, 36);
    chk("l0_cnt_36", {121'b0, dut.l0_cnt_q}, 128'd36);
    l0_pop(36, 1'b0, 1'b1, 1'b0);
    idle(20);
    chk("of_cnt_36", {121'b0, dut.of_cnt_q}, 128'd36);
    chk("valid_full", {127'b0, valid}, 128'd1);
    drain(11'd0, 36);
    chk("of_cnt_drained", {121'b0, dut.of_cnt_q}, 128'd0);
    chk("valid_drained", {127'b0, valid}, 128'd0);
    chk("pmem0_ones", dut.pmem[0], ALL8);
    chk("pmem17_ones", dut.pmem[17], ALL8);
    chk("pmem35_ones", dut.pmem[35], ALL8);

    // pops on empty FIFOs
    drain(11'd200, 1);
    chk("pmem_empty_pop_zero", dut.pmem[200], 128'd0);
    l0_pop(4, 1'b0, 1'b1, 1'b0);
    idle(20);
    chk("of_cnt_empty_exec", {121'b0, dut.of_cnt_q}, 128'd0);
    chk("l0_cnt_empty_exec", {121'b0, dut.l0_cnt_q}, 128'd0);
    chk("valid_empty_exec", {127'b0, valid}, 128'd0);

    // negative weight on one row only, WS then OS
    for (int k = 0; k < 8; k++) xwr(11'(1024 + k), 32'h0000_0F00);
    xwr(11'd36, 32'h0000_0F00);
    l0_fill(11'd1024, 8);
    l0_pop(8, 1'b1, 1'b0, 1'b0);
    l0_fill(11'd36, 1);
    l0_pop(1, 1'b0, 1'b1, 1'b0);
    idle(20);
    drain(11'd100, 1);
    chk("pmem100_ws_neg", dut.pmem[100], NEG15);
    l0_fill(11'd36, 1);
    l0_pop(1, 1'b0, 1'b1, 1'b1);
    idle(2);
    chk("os_of_cnt", {121'b0, dut.of_cnt_q}, 128'd1);
    drain(11'd102, 1);
    chk("pmem102_os_neg", dut.pmem[102], NEG15);

    // distinct per-column weights, WS then OS
    for (int k = 0; k < 8; k++) xwr(11'(1024 + k), wk[k]);
    xwr(11'd37, 32'h8765_4321);
    l0_fill(11'd1024, 8);
    l0_pop(8, 1'b1, 1'b0, 1'b0);
    l0_fill(11'd37, 1);
    l0_pop(1, 1'b0, 1'b1, 1'b0);
    idle(20);
    drain(11'd101, 1);
    chk("pmem101_ws_mix", dut.pmem[101], MIX);
    l0_fill(11'd37, 1);
    l0_pop(1, 1'b0, 1'b1, 1'b1);
    idle(20);
    drain(11'd103, 1);
    chk("pmem103_os_mix", dut.pmem[103], MIX);

    // accumulate and ReLU
    accp(11'd100);
    chk("sfp_neg15", coreOut, 128'd0);
    accp(11'd0);
    chk("sfp_neg7", coreOut, 128'd0);
    accp(11'd1);
    chk("sfp_pos1", coreOut, ONES);
    accp(11'd101);
    chk("sfp_mix", coreOut, SFP2);

    // reset in the middle of an execute pass
    l0_fill(11'd0, 36);
    l0_pop(20, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_valid", {127'b0, valid}, 128'd1);
    ex_i = nop();
    ex_i[INST_L0_RD] = 1'b1;
    ex_i[INST_EXECUTE] = 1'b1;
    inst = ex_i;
    reset = 1'b0;
    #1;
    chk("midrst_valid", {127'b0, valid}, 128'd0);
    chk("midrst_coreout", coreOut, 128'd0);
    chk("midrst_l0_cnt", {121'b0, dut.l0_cnt_q}, 128'd0);
    chk("midrst_of_cnt", {121'b0, dut.of_cnt_q}, 128'd0);
    @(negedge clk);
    @(negedge clk);
    inst = nop();
    reset = 1'b1;
    idle(25);
    chk("post_rst_of_cnt", {121'b0, dut.of_cnt_q}, 128'd0);
    chk("post_rst_valid", {127'b0, valid}, 128'd0);
    chk("post_rst_coreout", coreOut, 128'd0);
    xrd(11'd101, 1'b0);
    chk("xmem_retained", {96'b0, dut.xq_q}, {96'b0, pat[1]});
    chk("pmem_retained", dut.pmem[100], NEG15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
